mul_post_stage: RTL and testbench
=================================

# mul_post_stage

Registered post-processing stage directly downstream of the vector lane's combinational multiplier, consuming its raw 2·DATA_WIDTH product. It does four things:
- selects the low or high product half for MUL, MULH, MULHU and MULHSU;
- applies the signed×unsigned correction the multiplier cannot perform natively;
- performs the accumulate step for MACC and NMSAC;
- returns one DATA_WIDTH element per accepted product through a 2-stage valid/ready pipeline with backpressure.

## Interface
- DATA_WIDTH, 32, element width; product input is 2·DATA_WIDTH.
- module_clk_i  in  1  clock.
- module_rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all in-flight elements.
- valid_i  in  1  product_i and sideband valid.
- ready_o  out  1  stage can accept this cycle.
- product_i  in  2·DATA_WIDTH  multiplier result. Operand signedness (tc) was set upstream by op.
- op_i  in  3  mul_op_e operation.
- acc_i  in  DATA_WIDTH  accumulator operand for MACC/NMSAC.
- a_msb_i  in  1  sign bit of operand a, used by MULHSU.
- b_i  in  DATA_WIDTH  operand b, used by the MULHSU correction.
- valid_o  out  1  result_o valid.
- ready_i  in  1  consumer accepts.
- result_o  out  DATA_WIDTH  element result.
- err_o  out  1  reserved op_i code; qualified by valid_o.
- busy_o  out  1  any stage holds a valid element.

## Operation
Input acceptance:
- Transfer occurs when valid_i && ready_o.
- Stage 1 (S1) registers product, op, acc, a_msb and b.

Stage 2 (S2) computes from S1 contents and registers result, err and valid. P = product, lo = P[W-1:0], hi = P[2W-1:W], all arithmetic modulo 2^W:
- MUL: lo.
- MULH, MULHU: hi. The upstream tc selects the signedness.
- MULHSU: hi − (a_msb ? b : 0). Upstream multiplies unsigned (tc=0); this subtraction converts the result to signed×unsigned.
- MACC: acc + lo.
- NMSAC: acc − lo.
- Codes 6 and 7 (reserved): result 0, err_o=1.

Pipeline control:
- S2 advance = !valid_o || ready_i.
- S1 advance = S2 advance.
- ready_o = !s1_valid || S1 advance. This is a combinational path from ready_i; there is no skid buffer.
- While valid_o && !ready_i, result_o, err_o and valid_o hold stable.

Flush:
- flush_i clears s1_valid and valid_o on the next edge.
- An input offered in the flush cycle is dropped. ready_o stays as computed; the flush takes priority over the load.

Other rules:
- busy_o = s1_valid || valid_o.
- Results are delivered strictly in acceptance order; no element is lost or duplicated.

## Timing
- Reset (async assert, sync release) forces the outputs and state below to these values:
  - valid_o=0, result_o=0, err_o=0, busy_o=0, s1_valid=0;
  - ready_o=1 while out of reset.
- Latency: input accepted at edge N → valid_o high after edge N+1 (result visible in cycle N+1).
- Throughput: one element per cycle while ready_i=1.
- Full: S1 and S2 both valid with ready_i=0 → ready_o=0.
- Simultaneous S2 drain and S1 load in one cycle is required and must not create a bubble.
- Reset asserted mid-operation discards all elements immediately, without waiting for a clock.
- flush_i asserted together with ready_i: the element presented on result_o in that cycle counts as consumed; everything else is killed.

## Structure
- mul_pkg holds:
  - typedef enum logic [2:0] mul_op_e: MUL=0, MULH=1, MULHU=2, MULHSU=3, MACC=4, NMSAC=5.
  - MUL_OP_W=3.
  - Helper function op_needs_tc(mul_op_e), used upstream to drive tc.
- One natural sub-module: mul_post_alu. It is the combinational S2 datapath: half select, MULHSU correction, accumulate, err.
- The pipeline registers and control stay in mul_post_stage.

## Test plan
All values at DATA_WIDTH=32.
- MUL, product 0x00000001_00000002 → result_o 0x00000002 with valid_o one cycle after acceptance; err_o=0.
- MULH, product 0xFFFFFFFF_FFFFFFFA (−2×3) → 0xFFFFFFFF. MULHU, product 0x00000001_FFFFFFFE → 0x00000001.
- MULHSU, a=0xFFFFFFFF (a_msb=1), b=2, unsigned product 0x00000001_FFFFFFFE → 0xFFFFFFFF (−2 high half).
- MACC, acc=0xFFFFFFFF, lo=1 → 0x00000000. NMSAC, acc=10, lo=5 → 5. op=6 → result 0, err_o=1.
- Backpressure: issue 4 back-to-back elements with ready_i=0 for 3 cycles:
  - ready_o falls after 2 elements are held;
  - when ready_i returns, all 4 emerge in order with no loss or duplication;
  - valid_o, result_o and err_o stay stable while stalled.
- flush_i with both stages full → valid_o=0 and busy_o=0 next cycle. Async reset asserted mid-stream → valid_o drops immediately; ready_o=1 after release.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the vector-lane multiplier post-processing stage.
//   mul_op_e    : operation codes carried with each product (codes 6/7 reserved)
//   MUL_OP_W    : width of the operation field
//   op_needs_tc : whether the upstream multiplier must treat operands as signed
package mul_pkg;

    localparam int unsigned MUL_OP_W = 3;

    typedef enum logic [MUL_OP_W-1:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHU  = 3'd2,
        MULHSU = 3'd3,
        MACC   = 3'd4,
        NMSAC  = 3'd5
    } mul_op_e;

    // Only MULH needs a signed x signed product. MULHSU is multiplied unsigned
    // and corrected afterwards; low-half results do not depend on signedness.
    function automatic logic op_needs_tc(mul_op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/mul_post_stage_if.sv
// Handshake/data bundle for mul_post_stage.
//   upstream   : flush_i, valid_i, ready_o, product_i, op_i, acc_i, a_msb_i, b_i
//   downstream : valid_o, ready_i, result_o, err_o
//   status     : busy_o
// slave modport is the stage's view; master modport is the driver/consumer view.
interface mul_post_stage_if
    import mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      flush_i;
    logic                      valid_i;
    logic                      ready_o;
    logic [2*DATA_WIDTH-1:0]   product_i;
    logic [MUL_OP_W-1:0]       op_i;
    logic [DATA_WIDTH-1:0]     acc_i;
    logic                      a_msb_i;
    logic [DATA_WIDTH-1:0]     b_i;
    logic                      valid_o;
    logic                      ready_i;
    logic [DATA_WIDTH-1:0]     result_o;
    logic                      err_o;
    logic                      busy_o;

    modport slave (
        input  flush_i, valid_i, product_i, op_i, acc_i, a_msb_i, b_i, ready_i,
        output ready_o, valid_o, result_o, err_o, busy_o
    );

    modport master (
        output flush_i, valid_i, product_i, op_i, acc_i, a_msb_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, err_o, busy_o
    );
endinterface

// File: rtl/mul_post_alu.sv
// Combinational second-stage datapath: selects the product half, applies the
// MULHSU signed x unsigned correction, performs MACC/NMSAC accumulation and
// flags reserved op codes.
//   product : raw 2*DATA_WIDTH multiplier result
//   op      : operation code
//   acc     : accumulator operand (MACC/NMSAC)
//   a_msb   : sign bit of operand a (MULHSU)
//   b       : operand b (MULHSU correction)
//   result  : element result, modulo 2^DATA_WIDTH
//   err     : reserved op code seen (result forced to 0)
module mul_post_alu
    import mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] product,
    input  logic [MUL_OP_W-1:0]     op,
    input  logic [DATA_WIDTH-1:0]   acc,
    input  logic                    a_msb,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    err
);
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] hi;

    assign lo = product[DATA_WIDTH-1:0];
    assign hi = product[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            MUL:         result = lo;
            MULH, MULHU: result = hi;
            // Unsigned product of a negative a is too large by b * 2^W;
            // removing b from the high half yields the signed x unsigned value.
            MULHSU:      result = hi - (a_msb ? b : '0);
            MACC:        result = acc + lo;
            NMSAC:       result = acc - lo;
            default:     err    = 1'b1;
        endcase
    end
endmodule

// File: rtl/mul_post_stage.sv
// Registered post-processing stage behind the lane multiplier. Two-stage
// valid/ready pipeline: S1 captures the product and sideband, S2 holds the
// computed element. One element per cycle with ready_i high; no skid buffer,
// so ready_o depends combinationally on ready_i.
//   module_clk_i  : clock
//   module_rst_ni : asynchronous active-low reset
//   bus           : handshake/data bundle (slave view), see mul_post_stage_if
module mul_post_stage
    import mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           module_clk_i,
    input  logic           module_rst_ni,
    mul_post_stage_if.slave bus
);
    logic                    s1_valid;
    logic [2*DATA_WIDTH-1:0] s1_product;
    logic [MUL_OP_W-1:0]     s1_op;
    logic [DATA_WIDTH-1:0]   s1_acc;
    logic                    s1_a_msb;
    logic [DATA_WIDTH-1:0]   s1_b;

    logic                    s2_valid;
    logic [DATA_WIDTH-1:0]   s2_result;
    logic                    s2_err;

    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_err;
    logic                    advance;
    logic                    load;

    assign advance     = !s2_valid || bus.ready_i;
    assign bus.ready_o = !s1_valid || advance;
    assign load        = bus.valid_i && bus.ready_o;

    assign bus.valid_o  = s2_valid;
    assign bus.result_o = s2_result;
    assign bus.err_o    = s2_err;
    assign bus.busy_o   = s1_valid || s2_valid;

    mul_post_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .product(s1_product),
        .op     (s1_op),
        .acc    (s1_acc),
        .a_msb  (s1_a_msb),
        .b      (s1_b),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
        if (!module_rst_ni) begin
            s1_valid   <= 1'b0;
            s1_product <= '0;
            s1_op      <= '0;
            s1_acc     <= '0;
            s1_a_msb   <= 1'b0;
            s1_b       <= '0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_err     <= 1'b0;
        end else begin
            // S1 data may refresh during a flush; only the valid bits matter.
            if (load) begin
                s1_product <= bus.product_i;
                s1_op      <= bus.op_i;
                s1_acc     <= bus.acc_i;
                s1_a_msb   <= bus.a_msb_i;
                s1_b       <= bus.b_i;
            end
            if (bus.flush_i) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (advance) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_result <= alu_result;
                        s2_err    <= alu_err;
                    end
                end
                if (bus.ready_o) begin
                    s1_valid <= bus.valid_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_post_stage.sv
// Self-checking bench for mul_post_stage: directed operation cases,
// backpressure, flush and asynchronous reset, then a randomized stream
// scored against an ordered-queue model of the two-slot pipeline.
module tb_mul_post_stage;
    import mul_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_post_stage_if #(.DATA_WIDTH(W)) bus_if ();

    mul_post_stage #(.DATA_WIDTH(W)) dut (
        .module_clk_i (clk),
        .module_rst_ni(rst_n),
        .bus          (bus_if)
    );

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t q[$];          // elements in flight, oldest first
    bit   head_out;      // oldest element is presented on result_o
    int   checks    = 0;
    int   failures  = 0;
    int   delivered = 0;

    function automatic exp_t ref_model(logic [2:0] op, logic [63:0] p,
                                       logic [31:0] acc, logic amsb, logic [31:0] b);
        exp_t e;
        logic [31:0] lo;
        logic [31:0] hi;
        lo = p[31:0];
        hi = p[63:32];
        e.res = 32'd0;
        e.err = 1'b0;
        case (op)
            3'd0:       e.res = lo;
            3'd1, 3'd2: e.res = hi;
            3'd3:       e.res = amsb ? hi - b : hi;
            3'd4:       e.res = acc + lo;
            3'd5:       e.res = acc - lo;
            default:    e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(logic [2:0] op, logic [63:0] p, logic [31:0] acc,
                          logic amsb, logic [31:0] b);
        bus_if.op_i      = op;
        bus_if.product_i = p;
        bus_if.acc_i     = acc;
        bus_if.a_msb_i   = amsb;
        bus_if.b_i       = b;
    endtask

    // Entered shortly after a rising edge with inputs already driven.
    task automatic cycle();
        bit   rdy;
        bit   accept;
        bit   rdy_i;
        bit   flush;
        exp_t e;
        #4;
        rdy_i  = bus_if.ready_i;
        flush  = bus_if.flush_i;
        rdy    = (q.size() < 2) || rdy_i;
        check("ready_o", {63'd0, bus_if.ready_o}, {63'd0, rdy});
        accept = bus_if.valid_i && rdy;
        e = ref_model(bus_if.op_i, bus_if.product_i, bus_if.acc_i,
                      bus_if.a_msb_i, bus_if.b_i);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
            head_out = 1'b0;
        end else begin
            if (head_out && rdy_i) begin
                void'(q.pop_front());
                head_out = 1'b0;
                delivered++;
            end
            if (!head_out && q.size() > 0) head_out = 1'b1;
            if (accept) q.push_back(e);
        end
        check("valid_o", {63'd0, bus_if.valid_o}, {63'd0, head_out});
        if (head_out) begin
            check("result_o", {32'd0, bus_if.result_o}, {32'd0, q[0].res});
            check("err_o", {63'd0, bus_if.err_o}, {63'd0, q[0].err});
        end
        check("busy_o", {63'd0, bus_if.busy_o}, {63'd0, q.size() > 0});
    endtask

    task automatic send_one(string tag, logic [2:0] op, logic [63:0] p, logic [31:0] acc,
                            logic amsb, logic [31:0] b, logic [31:0] exp_res, logic exp_err);
        set_in(op, p, acc, amsb, b);
        bus_if.valid_i = 1'b1;
        bus_if.ready_i = 1'b1;
        cycle();
        bus_if.valid_i = 1'b0;
        cycle();
        check({tag, "_valid"}, {63'd0, bus_if.valid_o}, 64'd1);
        check(tag, {32'd0, bus_if.result_o}, {32'd0, exp_res});
        check({tag, "_err"}, {63'd0, bus_if.err_o}, {63'd0, exp_err});
        cycle();
    endtask

    logic [63:0] bp_prod [4];

    initial begin
        bus_if.flush_i = 1'b0;
        bus_if.valid_i = 1'b0;
        bus_if.ready_i = 1'b1;
        set_in(3'd0, 64'd0, 32'd0, 1'b0, 32'd0);
        head_out = 1'b0;

        #2;
        check("rst_valid_o", {63'd0, bus_if.valid_o}, 64'd0);
        check("rst_result_o", {32'd0, bus_if.result_o}, 64'd0);
        check("rst_err_o", {63'd0, bus_if.err_o}, 64'd0);
        check("rst_busy_o", {63'd0, bus_if.busy_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_o", {63'd0, bus_if.ready_o}, 64'd1);

        // Directed operation cases.
        send_one("mul",    3'd0, 64'h00000001_00000002, 32'd0, 1'b0, 32'd0, 32'h00000002, 1'b0);
        send_one("mulh",   3'd1, 64'hFFFFFFFF_FFFFFFFA, 32'd0, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0);
        send_one("mulhu",  3'd2, 64'h00000001_FFFFFFFE, 32'd0, 1'b0, 32'd0, 32'h00000001, 1'b0);
        send_one("mulhsu", 3'd3, 64'h00000001_FFFFFFFE, 32'd0, 1'b1, 32'd2, 32'hFFFFFFFF, 1'b0);
        send_one("macc",   3'd4, 64'h00000000_00000001, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h00000000, 1'b0);
        send_one("nmsac",  3'd5, 64'h00000000_00000005, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0);
        send_one("rsvd6",  3'd6, 64'h12345678_9ABCDEF0, 32'd7, 1'b1, 32'd9, 32'd0, 1'b1);

        // Backpressure: four back-to-back elements, consumer stalled 3 cycles.
        bp_prod[0] = 64'h0000000A_00000011;
        bp_prod[1] = 64'h0000000B_00000022;
        bp_prod[2] = 64'h0000000C_00000033;
        bp_prod[3] = 64'h0000000D_00000044;
        delivered = 0;
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
                bit acc_now;
                bus_if.ready_i = (c >= 3);
                if (idx < 4) begin
                    set_in(3'd0, bp_prod[idx], 32'd0, 1'b0, 32'd0);
                    bus_if.valid_i = 1'b1;
                end else begin
                    bus_if.valid_i = 1'b0;
                end
                if (c == 2) begin
                    #1;
                    check("bp_full_ready_o", {63'd0, bus_if.ready_o}, 64'd0);
                end
                acc_now = bus_if.valid_i && ((q.size() < 2) || bus_if.ready_i);
                cycle();
                if (acc_now) idx++;
            end
            bus_if.valid_i = 1'b0;
            check("bp_delivered", delivered, 64'd4);
            check("bp_drained", q.size(), 64'd0);
        end

        // Flush with both stages full; the element offered alongside is dropped.
        bus_if.ready_i = 1'b0;
        bus_if.valid_i = 1'b1;
        set_in(3'd4, 64'd5, 32'd1, 1'b0, 32'd0);
        cycle();
        cycle();
        cycle();
        check("fl_pre_busy", {63'd0, bus_if.busy_o}, 64'd1);
        bus_if.flush_i = 1'b1;
        cycle();
        bus_if.flush_i = 1'b0;
        bus_if.valid_i = 1'b0;
        check("fl_valid_o", {63'd0, bus_if.valid_o}, 64'd0);
        check("fl_busy_o", {63'd0, bus_if.busy_o}, 64'd0);
        bus_if.ready_i = 1'b1;
        cycle();

        // Randomized stream with occasional flushes and stalls.
        for (int n = 0; n < 400; n++) begin
            bus_if.valid_i = ($urandom_range(3) != 0);
            bus_if.ready_i = ($urandom_range(3) != 0);
            bus_if.flush_i = ($urandom_range(31) == 0);
            set_in(3'($urandom_range(7)), {$urandom, $urandom}, $urandom,
                   1'($urandom_range(1)), $urandom);
            cycle();
        end
        bus_if.flush_i = 1'b0;

        // Asynchronous reset mid-stream.
        bus_if.ready_i = 1'b0;
        bus_if.valid_i = 1'b1;
        cycle();
        cycle();
        bus_if.valid_i = 1'b0;
        check("ar_pre_valid", {63'd0, bus_if.valid_o}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_o", {63'd0, bus_if.valid_o}, 64'd0);
        check("ar_busy_o", {63'd0, bus_if.busy_o}, 64'd0);
        check("ar_result_o", {32'd0, bus_if.result_o}, 64'd0);
        q.delete();
        head_out = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_ready_o", {63'd0, bus_if.ready_o}, 64'd1);
        @(posedge clk);
        #1;

        for (int n = 0; n < 60; n++) begin
            bus_if.valid_i = ($urandom_range(1) != 0);
            bus_if.ready_i = ($urandom_range(2) != 0);
            set_in(3'($urandom_range(7)), {$urandom, $urandom}, $urandom,
                   1'($urandom_range(1)), $urandom);
            cycle();
        end
        bus_if.valid_i = 1'b0;
        bus_if.ready_i = 1'b1;
        cycle();
        cycle();
        cycle();
        check("final_idle", {63'd0, bus_if.busy_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
